// File: rtl/pipe_series_ctrl.sv
// pipe_series_ctrl
// Batches up to DEPTH operands through an external 3-cycle series pipeline.
// Pass 0 issues the operands straight from the input handshake. Each later
// pass recirculates the captured partial results with the next coefficient
// select. After the last pass, results are presented in order on the output
// handshake.
module pipe_series_ctrl #(
  parameter int PASSES = 2,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // operand input
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic        in_last,
  // result output
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_ovf,
  output logic        out_last,
  // towards the series pipeline
  output logic [31:0] pipe_x,
  output logic [31:0] pipe_num,
  output logic [31:0] pipe_sum,
  output logic        pipe_addr,
  output logic        pipe_sel_sum,
  // from the series pipeline
  input  logic [31:0] pipe_out_x,
  input  logic [31:0] pipe_out_num,
  input  logic [31:0] pipe_out_sum,
  input  logic        pipe_ovf
);

  localparam int IW  = $clog2(DEPTH);      // entry index width
  localparam int NW  = $clog2(DEPTH + 1);  // entry count width
  localparam int LAT = 3;                  // pipeline latency in cycles

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    RECIRC,
    OUTPUT
  } state_t;

  state_t           state;
  logic             pass;        // current pass number
  logic [NW-1:0]    n_q;         // operands in the current batch
  logic [IW-1:0]    idx;         // recirculation / output entry pointer
  logic             addr_q;      // last coefficient select driven

  // in-flight tags, one slot per pipeline register stage
  logic [LAT-1:0]   tag_v;
  logic [IW-1:0]    tag_e [LAT];

  // per-entry result buffer
  logic [31:0]      buf_x   [DEPTH];
  logic [31:0]      buf_num [DEPTH];
  logic [31:0]      buf_sum [DEPTH];
  logic [DEPTH-1:0] ovf;

  logic             accept;
  logic             rc_issue;
  logic             issue;
  logic [IW-1:0]    issue_tag;
  logic             last_idx;
  logic             capture;
  logic [IW-1:0]    cap_tag;

  // handshake and issue decode
  assign in_ready  = rst_n && ((state == IDLE) || (state == FILL));
  assign accept    = in_valid && in_ready;
  assign rc_issue  = (state == RECIRC);
  assign issue     = accept || rc_issue;
  assign issue_tag = rc_issue ? idx : n_q[IW-1:0];
  assign last_idx  = ({1'b0, idx} == (n_q - NW'(1)));
  assign capture   = tag_v[LAT-1];
  assign cap_tag   = tag_e[LAT-1];

  // result presentation straight from the buffer entry under the pointer
  assign out_valid = (state == OUTPUT);
  assign out_sum   = out_valid ? buf_sum[idx] : '0;
  assign out_ovf   = out_valid && ovf[idx];
  assign out_last  = out_valid && last_idx;

  // pipeline input mux: fresh operand, recirculated entry, or idle zeros
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    pipe_x       = '0;
    pipe_num     = '0;
    pipe_sum     = '0;
    pipe_sel_sum = 1'b0;
    pipe_addr    = addr_q;
    if (accept) begin
      pipe_x    = in_x;
      pipe_num  = in_x;
      pipe_addr = 1'b0;
    end else if (rc_issue) begin
      pipe_x       = buf_x[idx];
      pipe_num     = buf_num[idx];
      pipe_sum     = buf_sum[idx];
      pipe_sel_sum = 1'b1;
      pipe_addr    = pass;
    end
  end

  // batch sequencing: fill, drain, recirculate, output
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement and block ordering.
    if (!rst_n) begin
      state <= IDLE;
      pass  <= 1'b0;
      n_q   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE, FILL: begin
          if (accept) begin
            n_q <= n_q + NW'(1);
            if (in_last || (n_q == NW'(DEPTH - 1))) state <= DRAIN;
            else                                   state <= FILL;
          end
        end
        DRAIN: begin
          // the oldest slot is captured this cycle, so only the younger two
          // have to be empty before the next phase may start
          if (!tag_v[0] && !tag_v[1]) begin
            idx <= '0;
            if ((int'(pass) + 1) < PASSES) begin
              pass  <= pass + 1'b1;
              state <= RECIRC;
            end else begin
              state <= OUTPUT;
            end
          end
        end
        RECIRC: begin
          if (last_idx) begin
            idx   <= '0;
            state <= DRAIN;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (last_idx) begin
              state <= IDLE;
              pass  <= 1'b0;
              n_q   <= '0;
              idx   <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in-flight tag shift register and held coefficient select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v  <= '0;
      addr_q <= 1'b0;
      for (int i = 0; i < LAT; i++) tag_e[i] <= '0;
    end else begin
      tag_v    <= {tag_v[LAT-2:0], issue};
      tag_e[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) tag_e[i] <= tag_e[i-1];
      addr_q   <= pipe_addr;
    end
  end

  // result capture into the entry named by the emerging tag
  always_ff @(posedge clk) begin
    // NOTE: the buffer is a plain storage array with no reset; every entry is
    // written by pass 0 before anything reads it.
    if (capture) begin
      buf_x[cap_tag]   <= pipe_out_x;
      buf_num[cap_tag] <= pipe_out_num;
      buf_sum[cap_tag] <= pipe_out_sum;
    end
  end

  // sticky overflow, restarted by the pass-0 capture of each entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
    end else if (capture) begin
      ovf[cap_tag] <= ((pass == 1'b0) ? 1'b0 : ovf[cap_tag]) | pipe_ovf;
    end
  end

endmodule
